serial_rx: RTL and testbench
============================

Name: serial_rx

Overview:
- Asynchronous serial byte receiver: 8N1 frames (start, 8 data bits LSB first, stop) on a single line in, parallel bytes out on a valid/ready handshake.
- Receive-side counterpart of the team's serial byte transmitter; pairs with it in the vlog loopback regression.
- Fixed bit period in clock cycles, mid-bit sampling, one-entry output buffer, framing and overrun error reporting.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 4..65535.
- SYNC_STAGES, 2, synchroniser flops on rxd; legal range 2..4.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rxd  input  1  serial line, idle high, asynchronous to clk.
- out_data  output  8  received byte, valid while out_valid=1.
- out_valid  output  1  byte held in output buffer.
- out_ready  input  1  consumer accepts when out_valid&&out_ready on a clk edge.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  sticky: completed byte dropped because buffer full.
- err_clr  input  1  synchronous clear of overrun.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (async assert, sync deassert by clk):
  - out_data=0, out_valid=0, frame_err=0, overrun=0, busy=0.
  - State=IDLE; synchroniser flops preset to 1.
- rxd passes SYNC_STAGES flops; rxs denotes the last stage. All decisions use rxs only.
- Bit-cycle counter cnt is 16 bits wide. HALF = CLKS_PER_BIT/2 (integer division).
- FSM states IDLE, START, DATA, STOP:
  - IDLE: rxs==0 -> START, cnt=HALF-1.
  - START: cnt!=0 -> decrement. At cnt==0:
    - rxs==0 -> DATA, cnt=CLKS_PER_BIT-1, bit index=0.
    - rxs==1 -> IDLE (glitch rejected, no error).
  - DATA: at cnt==0, shift rxs into shreg[7] (right shift, LSB first), reload cnt. After 8th sample -> STOP with cnt reloaded.
  - STOP: at cnt==0:
    - rxs==1 -> deliver shreg, -> IDLE.
    - rxs==0 -> frame_err=1 for one cycle, byte discarded, -> IDLE.
    - IDLE then waits for rxs==1 before arming again (no re-trigger on a held-low break).
- Delivery:
  - If out_valid==0, or out_ready==1 in the same cycle (simultaneous accept and delivery): out_data<=shreg, out_valid<=1 next cycle.
  - Else buffer unchanged, overrun<=1.
- Handshake:
  - out_valid falls the cycle after acceptance unless a delivery coincides.
  - out_data stable while out_valid && !out_ready.
- overrun: err_clr clears it. err_clr and a new overrun in the same cycle -> overrun=1 (set wins).
- Latency: stop-bit mid-sample edge to out_valid=1 is 1 cycle. Line falling edge to START entry is SYNC_STAGES+1 cycles.
- Reset mid-frame: partial byte lost, no error flags, FSM restarts in IDLE.

Optional Feature:
- SERIAL_RX_PARITY_EN defined:
  - Frame becomes 8E1. An extra PARITY state between DATA and STOP samples a parity bit.
  - Added output parity_err (1 bit): one-cycle pulse in the STOP cycle when XOR(data,parity)!=0. The byte is discarded, as for a framing error.
  - Framing error takes precedence if both occur; only frame_err pulses.
- Not defined: no PARITY state and no parity_err port; 8N1 only.

Test Plan (CLKS_PER_BIT=4, SYNC_STAGES=2):
- Frame 0xA5, out_ready=1 -> out_valid=1 for exactly one cycle with out_data=8'hA5, frame_err=0, busy returns 0.
- Bytes 0x3C then 0xC3 back-to-back, out_ready=0 -> out_data stays 8'h3C, overrun=1. Assert err_clr -> overrun=0. Raise out_ready -> 8'h3C is accepted.
- 0x55 frame with stop bit low -> frame_err pulses once, out_valid stays 0. Hold rxd low 40 cycles -> no further frames or errors.
- rxd low for 1 cycle only (glitch) -> START aborts to IDLE, no out_valid, no error.
- rst_n low mid-DATA of 0xFF, then release and send 0x12 -> only 8'h12 is delivered.
- With SERIAL_RX_PARITY_EN: 0x07 with even parity bit 1 -> delivered. Same frame with parity bit 0 -> parity_err pulse, no delivery.

Source files
------------

// File: rtl/serial_rx.sv
// 8N1 serial byte receiver with mid-bit sampling, a one-entry valid/ready output buffer,
// framing and overrun reporting. Define SERIAL_RX_PARITY_EN for 8E1 frames plus parity_err.
module serial_rx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_err,
`ifdef SERIAL_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       overrun,
    input  logic       err_clr,
    output logic       busy
);

    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_M1  = 16'(CLKS_PER_BIT - 1);

`ifdef SERIAL_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sync;
    logic                   rxs;
    logic [15:0]            cnt, cnt_n;
    logic [2:0]             bitidx, bitidx_n;
    logic [7:0]             shreg, shreg_n;
    logic                   armed, armed_n;
    logic                   deliver, ferr;
`ifdef SERIAL_RX_PARITY_EN
    logic                   parbit, parbit_n;
    logic                   perr;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= '1;
        else        sync <= {sync[SYNC_STAGES-2:0], rxd};
    end
    assign rxs = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            bitidx <= '0;
            shreg  <= '0;
            armed  <= 1'b1;
`ifdef SERIAL_RX_PARITY_EN
            parbit <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            bitidx <= bitidx_n;
            shreg  <= shreg_n;
            armed  <= armed_n;
`ifdef SERIAL_RX_PARITY_EN
            parbit <= parbit_n;
`endif
        end
    end

    // armed drops after a framing error so a held-low break line cannot retrigger
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        bitidx_n = bitidx;
        shreg_n  = shreg;
        armed_n  = armed;
        deliver  = 1'b0;
        ferr     = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        parbit_n = parbit;
        perr     = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (rxs) begin
                    armed_n = 1'b1;
                end else if (armed) begin
                    state_n = START;
                    cnt_n   = HALF_M1;
                end
            end
            START: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 16'd1;
                end else if (!rxs) begin
                    state_n  = DATA;
                    cnt_n    = BIT_M1;
                    bitidx_n = '0;
                end else begin
                    state_n = IDLE;
                end
            end
            DATA: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 16'd1;
                end else begin
                    shreg_n  = {rxs, shreg[7:1]};
                    cnt_n    = BIT_M1;
                    bitidx_n = bitidx + 3'd1;
                    if (bitidx == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            PARITY: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 16'd1;
                end else begin
                    parbit_n = rxs;
                    cnt_n    = BIT_M1;
                    state_n  = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 16'd1;
                end else begin
                    state_n = IDLE;
                    if (!rxs) begin
                        ferr    = 1'b1;
                        armed_n = 1'b0;
                    end
`ifdef SERIAL_RX_PARITY_EN
                    else if (^{shreg, parbit}) perr = 1'b1;
`endif
                    else deliver = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= ferr;
`ifdef SERIAL_RX_PARITY_EN
            parity_err <= perr;
`endif
            if (deliver && (!out_valid || out_ready)) begin
                out_data  <= shreg;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (deliver && out_valid && !out_ready) overrun <= 1'b1;
            else if (err_clr)                         overrun <= 1'b0;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// Scoreboard bench for serial_rx at CLKS_PER_BIT=4, SYNC_STAGES=2; parity cases run
// when SERIAL_RX_PARITY_EN is defined.
module tb_serial_rx;

    localparam int unsigned CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic       out_ready = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;
`ifdef SERIAL_RX_PARITY_EN
    logic       parity_err;
`endif

    serial_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxd       (rxd),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err),
`ifdef SERIAL_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .overrun   (overrun),
        .err_clr   (err_clr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    logic [7:0]  exp_q[$];
    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    int unsigned n_deliv = 0;
    int unsigned n_ferr = 0;
    int unsigned n_perr = 0;
    int unsigned valid_cycles = 0;
    logic        busy_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, got, exp);
    endtask

    // Monitor: pops the expected byte whenever the DUT hands one over
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (out_valid) valid_cycles++;
                if (frame_err) n_ferr++;
`ifdef SERIAL_RX_PARITY_EN
                if (parity_err) n_perr++;
`endif
                if (busy) busy_seen = 1'b1;
                if (out_valid && out_ready) begin
                    n_deliv++;
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_byte: got %0h required none", out_data);
                    end else begin
                        check("rx_byte", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef SERIAL_RX_PARITY_EN
        send_bit(^d);
`endif
        send_bit(stop);
    endtask

`ifdef SERIAL_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] d, input logic par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(1'b1);
    endtask
`endif

    initial begin
        // reset state
        tick(3);
        @(negedge clk);
        check("rst_out_data", {24'd0, out_data}, 32'h0);
        check("rst_out_valid", {31'd0, out_valid}, 32'h0);
        check("rst_frame_err", {31'd0, frame_err}, 32'h0);
        check("rst_overrun", {31'd0, overrun}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(3);

        // single byte, consumer always ready
        out_ready = 1'b1;
        valid_cycles = 0;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        tick(8);
        @(negedge clk);
        check("a5_valid_cycles", valid_cycles, 32'd1);
        check("a5_delivered", n_deliv, 32'd1);
        check("a5_no_frame_err", n_ferr, 32'd0);
        check("a5_busy_idle", {31'd0, busy}, 32'h0);

        // back-to-back bytes into a stalled buffer
        @(posedge clk); #1;
        out_ready = 1'b0;
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        tick(8);
        @(negedge clk);
        check("ovr_out_valid", {31'd0, out_valid}, 32'h1);
        check("ovr_out_data", {24'd0, out_data}, 32'h3C);
        check("ovr_overrun", {31'd0, overrun}, 32'h1);
        @(posedge clk); #1;
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        @(negedge clk);
        check("ovr_cleared", {31'd0, overrun}, 32'h0);
        check("ovr_data_held", {24'd0, out_data}, 32'h3C);
        exp_q.push_back(8'h3C);
        @(posedge clk); #1;
        out_ready = 1'b1;
        tick(4);
        @(negedge clk);
        check("ovr_accepted", n_deliv, 32'd2);
        check("ovr_valid_drop", {31'd0, out_valid}, 32'h0);

        // framing error followed by a held-low line
        @(posedge clk); #1;
        send_frame(8'h55, 1'b0);
        tick(40);
        @(negedge clk);
        check("ferr_pulses", n_ferr, 32'd1);
        check("ferr_no_deliv", n_deliv, 32'd2);
        check("ferr_break_idle", {31'd0, busy}, 32'h0);
        @(posedge clk); #1;
        rxd = 1'b1;
        tick(10);

        // one-cycle glitch
        busy_seen = 1'b0;
        rxd = 1'b0;
        tick(1);
        rxd = 1'b1;
        tick(10);
        @(negedge clk);
        check("glitch_started", {31'd0, busy_seen}, 32'h1);
        check("glitch_idle", {31'd0, busy}, 32'h0);
        check("glitch_no_deliv", n_deliv, 32'd2);
        check("glitch_no_ferr", n_ferr, 32'd1);

        // reset in the middle of a frame
        @(posedge clk); #1;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        rst_n = 1'b0;
        tick(2);
        @(negedge clk);
        check("midrst_busy", {31'd0, busy}, 32'h0);
        check("midrst_valid", {31'd0, out_valid}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(4);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1);
        tick(8);
        @(negedge clk);
        check("midrst_deliv", n_deliv, 32'd3);
        check("midrst_no_ferr", n_ferr, 32'd1);
        check("midrst_no_overrun", {31'd0, overrun}, 32'h0);

`ifdef SERIAL_RX_PARITY_EN
        @(posedge clk); #1;
        exp_q.push_back(8'h07);
        send_frame_par(8'h07, 1'b1);
        tick(8);
        @(negedge clk);
        check("par_ok_deliv", n_deliv, 32'd4);
        check("par_ok_no_perr", n_perr, 32'd0);
        @(posedge clk); #1;
        send_frame_par(8'h07, 1'b0);
        tick(8);
        @(negedge clk);
        check("par_bad_perr", n_perr, 32'd1);
        check("par_bad_no_deliv", n_deliv, 32'd4);
        check("par_bad_no_ferr", n_ferr, 32'd1);
`endif

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
